// File: rtl/rc4_session_ctrl.sv
// rc4_session_ctrl: session sequencer for the RC4 keystream core.
// Takes a key/length configuration, fills the S-box RAM with the identity
// permutation, releases and starts the core, then XORs keystream bytes
// with the data stream until the programmed message length is emitted.
// Optional build macro RC4_DROP256_EN: discard the first 256 keystream
// bytes of each session before any data is processed.
//
// state | meaning
// IDLE  | core held in reset, waiting for a configuration
// FILL  | writing S[c] = c for c = 0..255
// ARM   | core out of reset, key presented, one cycle
// RUN   | core started, keystream XOR data stream
// FLUSH | last byte loaded, waiting for it to leave the output register
module rc4_session_ctrl #(
  parameter int KEY_BYTES_MAX = 4,
  parameter int KS_FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [8*KEY_BYTES_MAX-1:0] cfg_key,
  input  logic [7:0]                 cfg_key_len,
  input  logic [15:0]                cfg_msg_len,
  input  logic                       abort,
  output logic                       init_wen,
  output logic [7:0]                 init_addr,
  output logic [7:0]                 init_wdata,
  output logic                       core_rst_n,
  output logic                       core_start,
  output logic [8*KEY_BYTES_MAX-1:0] core_key,
  output logic [7:0]                 core_key_len,
  input  logic                       ks_valid,
  input  logic [7:0]                 ks_data,
  output logic                       ks_ready,
  input  logic                       din_valid,
  input  logic [7:0]                 din_data,
  output logic                       din_ready,
  output logic                       dout_valid,
  output logic [7:0]                 dout_data,
  output logic                       dout_last,
  input  logic                       dout_ready,
  output logic                       busy,
  output logic                       err,
  output logic                       done
);
  localparam int PW = $clog2(KS_FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARM, S_RUN, S_FLUSH} state_t;

  state_t                       state_q, state_d;
  logic                         alive_q;
  logic [7:0]                   fill_q, fill_d;
  logic [8*KEY_BYTES_MAX-1:0]   key_q, key_d;
  logic [7:0]                   klen_q, klen_d;
  logic [15:0]                  remain_q, remain_d;
  logic                         err_q, err_d;
  logic [7:0]                   mem_q [KS_FIFO_DEPTH];
  logic [PW-1:0]                wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]                  occ_q, occ_d;
  logic                         dv_q, dv_d, dl_q, dl_d;
  logic [7:0]                   dd_q, dd_d;
  logic                         cfg_legal, drop_done, ks_take, ks_push;
  logic                         din_fire, dout_fire, fifo_full, fifo_empty;

`ifdef RC4_DROP256_EN
  logic [8:0] drop_q, drop_d;
  assign drop_done = drop_q[8];
`else
  assign drop_done = 1'b1;
`endif

  assign cfg_legal  = (cfg_key_len != 8'd0) && (cfg_key_len <= 8'(KEY_BYTES_MAX)) &&
                      (cfg_msg_len != 16'd0);
  assign fifo_full  = (occ_q == (PW+1)'(KS_FIFO_DEPTH));
  assign fifo_empty = (occ_q == '0);

  assign cfg_ready    = alive_q && (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign err          = err_q;
  assign init_wen     = (state_q == S_FILL);
  assign init_addr    = fill_q;
  assign init_wdata   = fill_q;
  assign core_rst_n   = (state_q == S_ARM) || (state_q == S_RUN) || (state_q == S_FLUSH);
  assign core_start   = (state_q == S_RUN);
  assign core_key     = key_q;
  assign core_key_len = klen_q;

  // While dropping, keystream is sunk unconditionally and never reaches the FIFO.
  assign ks_ready  = (state_q == S_RUN) && (drop_done ? !fifo_full : 1'b1);
  assign ks_take   = ks_valid && ks_ready;
  assign ks_push   = ks_take && drop_done;
  assign din_ready = (state_q == S_RUN) && drop_done && !fifo_empty && (!dv_q || dout_ready);
  assign din_fire  = din_valid && din_ready;
  assign dout_fire = dv_q && dout_ready;
  assign done      = (state_q == S_FLUSH) && dout_fire && !abort;

  assign dout_valid = dv_q;
  assign dout_data  = dd_q;
  assign dout_last  = dl_q;

  // Next-state, FIFO pointer and output-register logic.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    key_d    = key_q;
    klen_d   = klen_q;
    remain_d = remain_q;
    err_d    = err_q;
    wptr_d   = wptr_q + PW'(ks_push);
    rptr_d   = rptr_q + PW'(din_fire);
    occ_d    = occ_q + (PW+1)'(ks_push) - (PW+1)'(din_fire);
    dv_d     = dv_q;
    dd_d     = dd_q;
    dl_d     = dl_q;
`ifdef RC4_DROP256_EN
    drop_d   = drop_q;
    if (state_q != S_RUN)
      drop_d = '0;
    else if (ks_take && !drop_done)
      drop_d = drop_q + 9'd1;
`endif

    if (din_fire) begin
      dv_d     = 1'b1;
      dd_d     = din_data ^ mem_q[rptr_q];
      dl_d     = (remain_q == 16'd1);
      remain_d = remain_q - 16'd1;
    end else if (dout_fire) begin
      dv_d = 1'b0;
      dl_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        fill_d = '0;
        if (cfg_valid && cfg_ready) begin
          if (cfg_legal) begin
            key_d    = cfg_key;
            klen_d   = cfg_key_len;
            remain_d = cfg_msg_len;
            err_d    = 1'b0;
            state_d  = S_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        fill_d = fill_q + 8'd1;
        if (fill_q == 8'd255) state_d = S_ARM;
      end
      S_ARM:   state_d = S_RUN;
      S_RUN:   if (din_fire && (remain_q == 16'd1)) state_d = S_FLUSH;
      S_FLUSH: begin
        if (dout_fire) begin
          state_d = S_IDLE;
          wptr_d  = '0;
          rptr_d  = '0;
          occ_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything else outside IDLE; err is left alone.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      wptr_d  = '0;
      rptr_d  = '0;
      occ_d   = '0;
      dv_d    = 1'b0;
      dd_d    = '0;
      dl_d    = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      alive_q  <= 1'b0;
      fill_q   <= '0;
      key_q    <= '0;
      klen_q   <= '0;
      remain_q <= '0;
      err_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      occ_q    <= '0;
      dv_q     <= 1'b0;
      dd_q     <= '0;
      dl_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      alive_q  <= 1'b1;
      fill_q   <= fill_d;
      key_q    <= key_d;
      klen_q   <= klen_d;
      remain_q <= remain_d;
      err_q    <= err_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      occ_q    <= occ_d;
      dv_q     <= dv_d;
      dd_q     <= dd_d;
      dl_q     <= dl_d;
    end
  end

  // Keystream FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KS_FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (ks_push) begin
      mem_q[wptr_q] <= ks_data;
    end
  end

`ifdef RC4_DROP256_EN
  // Count of keystream bytes discarded this session.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end
`endif

endmodule

// File: tb/tb_rc4_session_ctrl.sv
// Testbench for rc4_session_ctrl: random-rate keystream/data/ready drivers,
// a queue-based scoreboard fed by the stimulus, and an independent monitor
// that pops and compares every output handshake.
module tb_rc4_session_ctrl;
  logic        clk, rst_n;
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_key;
  logic [7:0]  cfg_key_len;
  logic [15:0] cfg_msg_len;
  logic        abort;
  logic        init_wen;
  logic [7:0]  init_addr, init_wdata;
  logic        core_rst_n, core_start;
  logic [31:0] core_key;
  logic [7:0]  core_key_len;
  logic        ks_valid, ks_ready;
  logic [7:0]  ks_data;
  logic        din_valid, din_ready;
  logic [7:0]  din_data;
  logic        dout_valid, dout_last, dout_ready;
  logic [7:0]  dout_data;
  logic        busy, err, done;

  rc4_session_ctrl #(.KEY_BYTES_MAX(4), .KS_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key),
    .cfg_key_len(cfg_key_len), .cfg_msg_len(cfg_msg_len), .abort(abort),
    .init_wen(init_wen), .init_addr(init_addr), .init_wdata(init_wdata),
    .core_rst_n(core_rst_n), .core_start(core_start), .core_key(core_key),
    .core_key_len(core_key_len),
    .ks_valid(ks_valid), .ks_data(ks_data), .ks_ready(ks_ready),
    .din_valid(din_valid), .din_data(din_data), .din_ready(din_ready),
    .dout_valid(dout_valid), .dout_data(dout_data), .dout_last(dout_last),
    .dout_ready(dout_ready),
    .busy(busy), .err(err), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int ks_rate = 100;
  int din_rate = 100;
  int rdy_rate = 100;
  bit hold_rdy = 1'b0;
  bit drv_flush = 1'b0;
  logic [7:0] ks_src[$];
  logic [7:0] din_src[$];
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Keystream source: presents queued bytes at a random rate.
  initial begin : ks_drv
    bit taken;
    taken = 1'b0;
    ks_valid = 1'b0;
    ks_data = '0;
    forever begin
      @(negedge clk);
      if (taken || drv_flush) ks_valid = 1'b0;
      taken = 1'b0;
      if (!ks_valid && !drv_flush && ks_src.size() > 0 && int'($urandom_range(99)) < ks_rate) begin
        ks_valid = 1'b1;
        ks_data = ks_src.pop_front();
      end
      #4;
      taken = ks_valid && ks_ready;
    end
  end

  // Data source: presents queued bytes at a random rate.
  initial begin : din_drv
    bit taken;
    taken = 1'b0;
    din_valid = 1'b0;
    din_data = '0;
    forever begin
      @(negedge clk);
      if (taken || drv_flush) din_valid = 1'b0;
      taken = 1'b0;
      if (!din_valid && !drv_flush && din_src.size() > 0 && int'($urandom_range(99)) < din_rate) begin
        din_valid = 1'b1;
        din_data = din_src.pop_front();
      end
      #4;
      taken = din_valid && din_ready;
    end
  end

  // Output sink ready.
  initial begin : rdy_drv
    dout_ready = 1'b0;
    forever begin
      @(negedge clk);
      dout_ready = !hold_rdy && (int'($urandom_range(99)) < rdy_rate);
    end
  end

  // Monitor: samples just before each rising edge.
  initial begin : mon
    bit pv, hs;
    logic [7:0] pd;
    logic pl;
    logic [8:0] e;
    pv = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        pv = 1'b0;
        continue;
      end
      if (pv) check("dout_hold", 64'({dout_valid, dout_last, dout_data}), 64'({1'b1, pl, pd}));
      hs = dout_valid && dout_ready;
      if (hs) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL dout_extra: got %0h expected no byte", dout_data);
        end else begin
          e = exp_q.pop_front();
          check("dout_byte", 64'({dout_last, dout_data}), 64'(e));
        end
      end
      if (done || (hs && dout_last)) check("done_pulse", 64'(done), 64'(hs && dout_last));
      if (done) done_cnt++;
      pv = dout_valid && !dout_ready && !abort;
      pd = dout_data;
      pl = dout_last;
    end
  end

  task automatic load_drop_prefix();
`ifdef RC4_DROP256_EN
    for (int i = 0; i < 256; i++) ks_src.push_back(8'($urandom));
`endif
  endtask

  task automatic load_random(input int n);
    logic [7:0] k, d;
    load_drop_prefix();
    for (int i = 0; i < n; i++) begin
      k = 8'($urandom);
      d = 8'($urandom);
      ks_src.push_back(k);
      din_src.push_back(d);
      exp_q.push_back({(i == n - 1), k ^ d});
    end
  endtask

  task automatic do_cfg(input logic [31:0] key, input logic [7:0] len, input logic [15:0] msg);
    int n;
    n = 0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_key = key;
    cfg_key_len = len;
    cfg_msg_len = msg;
    while (!cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cfg_ready_wait", 64'(cfg_ready), 64'(1));
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_end(input string name, input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, 64'(done_cnt - d0), 64'(1));
    @(negedge clk);
    check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
    check({name, "_idle"}, 64'({busy, core_rst_n, dout_valid}), 64'(0));
  endtask

  task automatic cleanup();
    drv_flush = 1'b1;
    repeat (2) @(negedge clk);
    ks_src.delete();
    din_src.delete();
    exp_q.delete();
    drv_flush = 1'b0;
    hold_rdy = 1'b0;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int d0, n;
    logic [7:0] bad_len[3];
    logic [15:0] bad_msg[3];
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_key = '0;
    cfg_key_len = '0;
    cfg_msg_len = '0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_wide", {8'h0, core_key, core_key_len, init_addr, init_wdata},
          64'(0));
    check("reset_flags", 64'({cfg_ready, init_wen, core_rst_n, core_start, ks_ready, din_ready,
                             dout_valid, dout_data, dout_last, busy, err, done}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("cfg_ready_after_reset", 64'(cfg_ready), 64'(1));

    // Directed session with fill and start timing.
    load_drop_prefix();
    ks_src.push_back(8'hAA); ks_src.push_back(8'h55); ks_src.push_back(8'hF0);
    din_src.push_back(8'h11); din_src.push_back(8'h22); din_src.push_back(8'h33);
    exp_q.push_back(9'h0BB); exp_q.push_back(9'h077); exp_q.push_back(9'h1C3);
    d0 = done_cnt;
    do_cfg(32'h0403_0201, 8'd4, 16'd3);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (!(init_wen && busy && init_addr == 8'(i) && init_wdata == 8'(i))) n++;
    end
    check("fill_sequence_errors", 64'(n), 64'(0));
    @(negedge clk);
    check("arm_ctrl", 64'({init_wen, core_rst_n, core_start}), 64'(3'b010));
    check("arm_key", 64'(core_key), 64'(32'h0403_0201));
    check("arm_key_len", 64'(core_key_len), 64'(4));
    @(negedge clk);
    check("start_at_T258", 64'({core_start, core_rst_n}), 64'(2'b11));
    wait_end("directed", d0);

    // Illegal configurations.
    bad_len[0] = 8'd0; bad_msg[0] = 16'd5;
    bad_len[1] = 8'd5; bad_msg[1] = 16'd5;
    bad_len[2] = 8'd4; bad_msg[2] = 16'd0;
    for (int i = 0; i < 3; i++) begin
      do_cfg(32'($urandom), bad_len[i], bad_msg[i]);
      @(negedge clk);
      check("illegal_err_busy_wen", 64'({err, busy, init_wen}), 64'(3'b100));
      @(negedge clk);
      check("illegal_stays_idle", 64'({busy, init_wen, cfg_ready}), 64'(3'b001));
    end

    // Random sessions, the first one also clearing err and using msg_len 1.
    for (int s = 0; s < 6; s++) begin
      ks_rate = int'($urandom_range(100, 30));
      din_rate = int'($urandom_range(100, 30));
      rdy_rate = int'($urandom_range(100, 30));
      n = (s == 0) ? 1 : int'($urandom_range(40, 2));
      load_random(n);
      d0 = done_cnt;
      do_cfg(32'($urandom), 8'($urandom_range(4, 1)), 16'(n));
      @(negedge clk);
      check("err_cleared", 64'({err, busy}), 64'(2'b01));
      wait_end("random", d0);
    end

    // Backpressure: hold dout_ready low for 10 cycles mid-stream.
    ks_rate = 100; din_rate = 100; rdy_rate = 100;
    load_random(12);
    d0 = done_cnt;
    do_cfg(32'($urandom), 8'd3, 16'd12);
    n = 0;
    while (exp_q.size() > 9 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("bp_reached", 64'(exp_q.size() <= 9), 64'(1));
    @(posedge clk);
    #1;
    hold_rdy = 1'b1;
    repeat (10) @(negedge clk);
    check("bp_full", 64'({ks_ready, din_ready, dout_valid}), 64'(3'b001));
    @(posedge clk);
    #1;
    hold_rdy = 1'b0;
    wait_end("backpressure", d0);

    // Abort during FILL at c = 100.
    d0 = done_cnt;
    do_cfg(32'($urandom), 8'd2, 16'd5);
    repeat (101) @(negedge clk);
    check("fill_c100", 64'({init_wen, init_addr}), 64'({1'b1, 8'd100}));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_fill", 64'({busy, core_rst_n, dout_valid, init_wen}), 64'(0));
    repeat (3) @(negedge clk);
    check("abort_fill_no_done", 64'(done_cnt - d0), 64'(0));

    // Abort during RUN with the output held and two bytes buffered.
    hold_rdy = 1'b1;
    load_drop_prefix();
    ks_src.push_back(8'($urandom)); ks_src.push_back(8'($urandom)); ks_src.push_back(8'($urandom));
    din_src.push_back(8'($urandom));
    d0 = done_cnt;
    do_cfg(32'($urandom), 8'd4, 16'd10);
    n = 0;
    while (!(dout_valid && ks_src.size() == 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("abort_run_pre", 64'({dout_valid, ks_ready, din_ready, busy}), 64'(4'b1101));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_run", 64'({busy, core_rst_n, dout_valid, din_ready, ks_ready}), 64'(0));
    cleanup();
    check("abort_run_no_done", 64'(done_cnt - d0), 64'(0));

    // Session after abort.
    ks_rate = 70; din_rate = 80; rdy_rate = 60;
    load_random(9);
    d0 = done_cnt;
    do_cfg(32'($urandom), 8'd1, 16'd9);
    wait_end("after_abort", d0);

    // Asynchronous reset mid-session.
    load_random(6);
    do_cfg(32'($urandom), 8'd2, 16'd6);
    repeat (260) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_mid_session", 64'({busy, core_rst_n, core_start, dout_valid, cfg_ready, init_wen}), 64'(0));
    cleanup();
    @(negedge clk);
    rst_n = 1'b1;

    // Final session after reset.
    load_random(7);
    d0 = done_cnt;
    do_cfg(32'($urandom), 8'd4, 16'd7);
    wait_end("after_reset", d0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
